// File: rtl/rename_stage_if.sv
// rtl/rename_stage_if.sv - decode, dispatch, commit and flush signal bundle for rename_stage
// slave modport faces the rename stage; master modport faces its environment.
interface rename_stage_if #(
  parameter int PHYS_REGS = 64,
  parameter int PC_W      = 9
);
  localparam int PTAG_W = $clog2(PHYS_REGS);

  logic              i_valid;
  logic              o_ready;
  logic [PC_W-1:0]   i_pc;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [4:0]        i_rd;
  logic [31:0]       i_immediate;
  logic [8:0]        i_ctrl;

  logic              o_valid;
  logic              i_ready;
  logic [PC_W-1:0]   o_pc;
  logic [31:0]       o_immediate;
  logic [8:0]        o_ctrl;
  logic [PTAG_W-1:0] o_prs1;
  logic [PTAG_W-1:0] o_prs2;
  logic [PTAG_W-1:0] o_prd;
  logic [PTAG_W-1:0] o_old_prd;

  logic              i_commit_valid;
  logic [4:0]        i_commit_rd;
  logic [PTAG_W-1:0] i_commit_prd;
  logic [PTAG_W-1:0] i_commit_old_prd;
  logic              i_flush;
  logic [31:0]       o_stall_cycles;

  modport slave (
    input  i_valid, i_pc, i_rs1, i_rs2, i_rd, i_immediate, i_ctrl, i_ready,
    input  i_commit_valid, i_commit_rd, i_commit_prd, i_commit_old_prd, i_flush,
    output o_ready, o_valid, o_pc, o_immediate, o_ctrl,
    output o_prs1, o_prs2, o_prd, o_old_prd, o_stall_cycles
  );

  modport master (
    output i_valid, i_pc, i_rs1, i_rs2, i_rd, i_immediate, i_ctrl, i_ready,
    output i_commit_valid, i_commit_rd, i_commit_prd, i_commit_old_prd, i_flush,
    input  o_ready, o_valid, o_pc, o_immediate, o_ctrl,
    input  o_prs1, o_prs2, o_prd, o_old_prd, o_stall_cycles
  );
endinterface

// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - register rename stage: RAT, circular free list, retirement RAT, flush recovery
// RENAME_PERF_CNT_EN builds the free-list-empty stall counter; otherwise o_stall_cycles is 0.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PTAG_W    = $clog2(PHYS_REGS),
  parameter int PC_W      = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  rename_stage_if.slave  bus
);
  localparam int DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTAG_W-1:0] r_rat      [ARCH_REGS];
  logic [PTAG_W-1:0] r_rrat     [ARCH_REGS];
  logic [PTAG_W-1:0] r_freelist [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W-1:0]  r_commit_head;

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_immediate;
  logic [8:0]        r_ctrl;
  logic [PTAG_W-1:0] r_prs1;
  logic [PTAG_W-1:0] r_prs2;
  logic [PTAG_W-1:0] r_prd;
  logic [PTAG_W-1:0] r_old_prd;

  logic              w_alloc;
  logic [PTR_W-1:0]  w_free_count;
  logic              w_ready;
  logic              w_accept;
  logic              w_commit_wr;
  logic [PTAG_W-1:0] w_new_prd;

  assign w_alloc      = bus.i_ctrl[0] && (bus.i_rd != 5'd0);
  assign w_free_count = r_tail - r_head;
  assign w_ready      = (!r_valid || bus.i_ready) && (!w_alloc || (w_free_count != '0)) && !bus.i_flush;
  assign w_accept     = bus.i_valid && w_ready;
  assign w_commit_wr  = bus.i_commit_valid && (bus.i_commit_rd != 5'd0);
  assign w_new_prd    = r_freelist[r_head[IDX_W-1:0]];

  // Flush rebuilds the speculative map from the RRAT including this cycle's commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rat[i]  <= PTAG_W'(i);
        r_rrat[i] <= PTAG_W'(i);
      end
    end else begin
      if (bus.i_flush) begin
        for (int i = 0; i < ARCH_REGS; i++)
          r_rat[i] <= (w_commit_wr && (bus.i_commit_rd == 5'(i))) ? bus.i_commit_prd : r_rrat[i];
      end else if (w_accept && w_alloc) begin
        r_rat[bus.i_rd] <= w_new_prd;
      end
      if (w_commit_wr)
        r_rrat[bus.i_commit_rd] <= bus.i_commit_prd;
    end
  end

  // Tail starts one full lap ahead of head so the list reads as full out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++)
        r_freelist[j] <= PTAG_W'(ARCH_REGS + j);
      r_head        <= '0;
      r_tail        <= PTR_W'(DEPTH);
      r_commit_head <= '0;
    end else begin
      if (bus.i_commit_valid) begin
        r_freelist[r_tail[IDX_W-1:0]] <= bus.i_commit_old_prd;
        r_tail        <= r_tail + PTR_W'(1);
        r_commit_head <= r_commit_head + PTR_W'(1);
      end
      if (bus.i_flush)
        r_head <= r_commit_head + PTR_W'(bus.i_commit_valid);
      else if (w_accept && w_alloc)
        r_head <= r_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_immediate <= '0;
      r_ctrl      <= '0;
      r_prs1      <= '0;
      r_prs2      <= '0;
      r_prd       <= '0;
      r_old_prd   <= '0;
    end else if (bus.i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_pc        <= bus.i_pc;
      r_immediate <= bus.i_immediate;
      r_ctrl      <= bus.i_ctrl;
      r_prs1      <= r_rat[bus.i_rs1];
      r_prs2      <= r_rat[bus.i_rs2];
      r_prd       <= w_alloc ? w_new_prd : '0;
      r_old_prd   <= w_alloc ? r_rat[bus.i_rd] : '0;
    end else if (bus.i_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef RENAME_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (bus.i_valid && w_alloc && (w_free_count == '0) && (r_stall_cycles != 32'hFFFF_FFFF))
      r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign bus.o_stall_cycles = r_stall_cycles;
`else
  assign bus.o_stall_cycles = 32'd0;
`endif

  assign bus.o_ready     = w_ready;
  assign bus.o_valid     = r_valid;
  assign bus.o_pc        = r_pc;
  assign bus.o_immediate = r_immediate;
  assign bus.o_ctrl      = r_ctrl;
  assign bus.o_prs1      = r_prs1;
  assign bus.o_prs2      = r_prs2;
  assign bus.o_prd       = r_prd;
  assign bus.o_old_prd   = r_old_prd;
endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - vector table, directed corner sequences and random run against a queue-based rename model
module tb_rename_stage;
  localparam int PHYS  = 64;
  localparam int PC_W  = 9;
  localparam logic [8:0] C_R  = 9'h041;
  localparam logic [8:0] C_I  = 9'h101;
  localparam logic [8:0] C_SW = 9'h10A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rename_stage_if #(.PHYS_REGS(PHYS), .PC_W(PC_W)) bus ();

  rename_stage #(.ARCH_REGS(32), .PHYS_REGS(PHYS), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int rd; int prd; int old; } alloc_t;
  int          m_rat [32];
  int          m_rrat[32];
  int          m_free[$];
  alloc_t      m_fly [$];
  bit          m_v;
  logic [8:0]  m_pc, m_ctrl;
  logic [31:0] m_imm;
  int          m_prs1, m_prs2, m_prd, m_old;
  longint      m_stall;
  logic        last_ready;

  typedef struct {
    bit rst; logic [8:0] pc; logic [4:0] rs1, rs2, rd; logic [8:0] ctrl; logic [31:0] imm;
    int e1; int e2; int ep; int eo;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rat[i] = i; m_rrat[i] = i; end
    m_free.delete();
    for (int j = 32; j < 64; j++) m_free.push_back(j);
    m_fly.delete();
    m_v = 0; m_pc = '0; m_ctrl = '0; m_imm = '0;
    m_prs1 = 0; m_prs2 = 0; m_prd = 0; m_old = 0; m_stall = 0;
  endtask

  task automatic idle();
    bus.i_valid = 0; bus.i_pc = '0; bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd = '0;
    bus.i_immediate = '0; bus.i_ctrl = '0; bus.i_ready = 1;
    bus.i_commit_valid = 0; bus.i_commit_rd = '0; bus.i_commit_prd = '0; bus.i_commit_old_prd = '0;
    bus.i_flush = 0;
  endtask

  task automatic instr(input logic [8:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [8:0] ctrl, input logic [31:0] imm);
    bus.i_valid = 1; bus.i_pc = pc; bus.i_rs1 = rs1; bus.i_rs2 = rs2; bus.i_rd = rd;
    bus.i_ctrl = ctrl; bus.i_immediate = imm;
  endtask

  task automatic commit(input int rd, input int prd, input int old);
    bus.i_commit_valid = 1; bus.i_commit_rd = 5'(rd);
    bus.i_commit_prd = 6'(prd); bus.i_commit_old_prd = 6'(old);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset o_valid", bus.o_valid, 0);
    chk("reset o_prd", bus.o_prd, 0);
    chk("reset o_prs1", bus.o_prs1, 0);
    chk("reset o_immediate", bus.o_immediate, 0);
    chk("reset o_stall", bus.o_stall_cycles, 0);
    rst_n = 1;
  endtask

  // One clock: predict from the model, check o_ready, advance, check registered outputs.
  task automatic cycle(input string tag);
    bit alloc, rdy, acc;
    alloc_t a, c;
    #1;
    alloc = bus.i_ctrl[0] && (bus.i_rd != 0);
    rdy   = (!m_v || bus.i_ready) && (!alloc || m_free.size() != 0) && !bus.i_flush;
    last_ready = bus.o_ready;
    chk({tag, " o_ready"}, bus.o_ready, rdy);
    if (bus.i_valid && alloc && m_free.size() == 0 && m_stall != 64'hFFFF_FFFF) m_stall++;
    acc = bus.i_valid && rdy;
    if (bus.i_commit_valid && m_fly.size() != 0) c = m_fly.pop_front();
    if (acc) begin
      m_pc = bus.i_pc; m_imm = bus.i_immediate; m_ctrl = bus.i_ctrl;
      m_prs1 = m_rat[bus.i_rs1]; m_prs2 = m_rat[bus.i_rs2];
      if (alloc) begin
        m_prd = m_free.pop_front(); m_old = m_rat[bus.i_rd];
        m_rat[bus.i_rd] = m_prd;
        a.rd = bus.i_rd; a.prd = m_prd; a.old = m_old;
        m_fly.push_back(a);
      end else begin
        m_prd = 0; m_old = 0;
      end
    end
    if (bus.i_commit_valid) begin
      m_rrat[bus.i_commit_rd] = bus.i_commit_prd;
      m_free.push_back(int'(bus.i_commit_old_prd));
    end
    if (bus.i_flush) begin
      for (int k = m_fly.size() - 1; k >= 0; k--) m_free.push_front(m_fly[k].prd);
      m_fly.delete();
      m_rat = m_rrat;
      m_v = 0;
    end else if (acc) m_v = 1;
    else if (bus.i_ready) m_v = 0;
    @(posedge clk);
    #1;
    chk({tag, " o_valid"}, bus.o_valid, m_v);
    if (m_v) begin
      chk({tag, " o_pc"}, bus.o_pc, m_pc);
      chk({tag, " o_immediate"}, bus.o_immediate, m_imm);
      chk({tag, " o_ctrl"}, bus.o_ctrl, m_ctrl);
      chk({tag, " o_prs1"}, bus.o_prs1, m_prs1);
      chk({tag, " o_prs2"}, bus.o_prs2, m_prs2);
      chk({tag, " o_prd"}, bus.o_prd, m_prd);
      chk({tag, " o_old_prd"}, bus.o_old_prd, m_old);
    end
`ifdef RENAME_PERF_CNT_EN
    chk({tag, " o_stall"}, bus.o_stall_cycles, m_stall);
`else
    chk({tag, " o_stall"}, bus.o_stall_cycles, 0);
`endif
  endtask

  initial begin
    tv[0] = '{1, 9'h010, 5'd2, 5'd3, 5'd1, C_R,  32'd0,   2, 3, 32, 1};
    tv[1] = '{1, 9'h014, 5'd5, 5'd0, 5'd4, C_I,  32'd100, 5, 0, 32, 4};
    tv[2] = '{0, 9'h018, 5'd4, 5'd4, 5'd5, C_R,  32'd0,  32, 32, 33, 5};
    tv[3] = '{1, 9'h01C, 5'd9, 5'd8, 5'd6, C_SW, 32'd12,  9, 8, 0, 0};
    tv[4] = '{0, 9'h020, 5'd2, 5'd3, 5'd1, C_R,  32'd0,   2, 3, 32, 1};
    tv[5] = '{0, 9'h024, 5'd1, 5'd2, 5'd0, C_R,  32'd0,  32, 2, 0, 0};
    tv[6] = '{0, 9'h028, 5'd0, 5'd1, 5'd7, C_R,  32'd0,   0, 32, 33, 7};

    idle();
    for (int v = 0; v < 7; v++) begin
      if (tv[v].rst) do_reset();
      instr(tv[v].pc, tv[v].rs1, tv[v].rs2, tv[v].rd, tv[v].ctrl, tv[v].imm);
      cycle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d valid", v), bus.o_valid, 1);
      chk($sformatf("vec%0d prs1", v), bus.o_prs1, tv[v].e1);
      chk($sformatf("vec%0d prs2", v), bus.o_prs2, tv[v].e2);
      chk($sformatf("vec%0d prd", v), bus.o_prd, tv[v].ep);
      chk($sformatf("vec%0d old_prd", v), bus.o_old_prd, tv[v].eo);
      idle();
    end

    // Free list exhaustion, non-alloc bypass, no same-cycle commit bypass.
    do_reset();
    for (int k = 0; k < 32; k++) begin
      instr(9'(k), 5'd2, 5'd3, 5'd1, C_R, 32'd0);
      cycle("fill");
      chk("fill prd", bus.o_prd, 32 + k);
    end
    instr(9'h100, 5'd2, 5'd3, 5'd1, C_R, 32'd0);
    cycle("empty0");
    chk("empty ready", last_ready, 0);
    cycle("empty1");
    instr(9'h104, 5'd9, 5'd8, 5'd0, C_SW, 32'd12);
    cycle("empty store");
    chk("empty store ready", last_ready, 1);
    chk("empty store prs1", bus.o_prs1, 9);
    instr(9'h108, 5'd2, 5'd3, 5'd1, C_R, 32'd0);
    commit(1, 32, 1);
    cycle("empty commit");
    chk("no bypass ready", last_ready, 0);
    bus.i_commit_valid = 0;
    cycle("refill");
    chk("refill ready", last_ready, 1);
    chk("refill prd", bus.o_prd, 1);
`ifdef RENAME_PERF_CNT_EN
    chk("stall count", bus.o_stall_cycles, 3);
`endif
    idle();

    // Dispatch backpressure holds the uop stable.
    do_reset();
    instr(9'h040, 5'd2, 5'd3, 5'd1, C_R, 32'd0);
    cycle("bp0");
    instr(9'h044, 5'd5, 5'd6, 5'd4, C_R, 32'd0);
    bus.i_ready = 0;
    for (int k = 0; k < 2; k++) begin
      cycle("bp hold");
      chk("bp ready", last_ready, 0);
      chk("bp hold prd", bus.o_prd, 32);
      chk("bp hold pc", bus.o_pc, 9'h040);
    end
    bus.i_ready = 1;
    cycle("bp drain");
    chk("bp drain ready", last_ready, 1);
    chk("bp next prd", bus.o_prd, 33);
    chk("bp next prs1", bus.o_prs1, 5);
    idle();

    // Flush with same-cycle commit restores the committed map and free list.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      instr(9'(k), 5'd1, 5'd1, 5'd1, C_R, 32'd0);
      cycle("fl ren");
      chk("fl ren prd", bus.o_prd, 32 + k);
    end
    instr(9'h060, 5'd1, 5'd0, 5'd2, C_R, 32'd0);
    commit(1, 32, 1);
    bus.i_flush = 1;
    cycle("flush");
    chk("flush ready", last_ready, 0);
    chk("flush valid", bus.o_valid, 0);
    bus.i_flush = 0; bus.i_commit_valid = 0;
    cycle("post flush");
    chk("post flush prs1", bus.o_prs1, 32);
    chk("post flush prs2", bus.o_prs2, 0);
    chk("post flush prd", bus.o_prd, 33);
    chk("post flush old", bus.o_old_prd, 2);
    idle();

    // Asynchronous reset mid-operation drops the in-flight uop at once.
    instr(9'h070, 5'd2, 5'd3, 5'd1, C_R, 32'd0);
    cycle("pre arst");
    #2;
    rst_n = 0;
    #1;
    chk("arst o_valid", bus.o_valid, 0);
    chk("arst o_prd", bus.o_prd, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      int cp;
      cp = (n < 1500) ? 25 : 55;
      idle();
      bus.i_valid = ($urandom_range(3) != 0);
      bus.i_pc = 9'($urandom); bus.i_rs1 = 5'($urandom); bus.i_rs2 = 5'($urandom);
      bus.i_rd = 5'($urandom); bus.i_ctrl = 9'($urandom); bus.i_immediate = $urandom;
      bus.i_ready = ($urandom_range(3) != 0);
      if (m_fly.size() != 0 && $urandom_range(99) < cp)
        commit(m_fly[0].rd, m_fly[0].prd, m_fly[0].old);
      bus.i_flush = ($urandom_range(99) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
